// File: rtl/seq_binary_to_bcd.sv
// seq_binary_to_bcd: multi-cycle binary to packed-BCD converter (shift-and-add-3).
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   conversion request, accepted only while idle
//   data_in  in   DATA_WIDTH binary operand, captured on the accepted start
//   busy     out  high from the cycle after acceptance until the result is published
//   done     out  one-cycle pulse coinciding with the bcd_out/sign_out update
//   bcd_out  out  4*DIGITS packed BCD, ones digit at [3:0]
//   sign_out out  1 when a two's-complement operand was negative (SIGNED_MODE=1)
module seq_binary_to_bcd #(
    parameter int DATA_WIDTH  = 8,
    parameter int DIGITS      = 3,
    parameter int SIGNED_MODE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    // True when DIGITS decimal digits can represent every value below 2**dw.
    function automatic bit digits_fit(input int dw, input int nd);
        longint lim;
        longint p;
        bit     ok;
        lim = longint'(1) << dw;
        p   = 1;
        ok  = 1'b0;
        for (int i = 0; i < nd; i++) begin
            if (!ok) begin
                p = p * 10;
                if (p > lim) ok = 1'b1;
            end
        end
        return ok;
    endfunction

    if (DATA_WIDTH < 4 || DATA_WIDTH > 32) begin : g_width_check
        $error("seq_binary_to_bcd: DATA_WIDTH must lie in 4..32");
    end
    if (!digits_fit(DATA_WIDTH, DIGITS)) begin : g_digits_check
        $error("seq_binary_to_bcd: 10**DIGITS must exceed 2**DATA_WIDTH");
    end

    // Absolute value formed one bit wider so the most negative operand
    // does not wrap; the result always fits back into DATA_WIDTH bits.
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v);
        logic signed [DATA_WIDTH:0] wide;
        logic signed [DATA_WIDTH:0] mag;
        wide = (SIGNED_MODE != 0) ? $signed({v[DATA_WIDTH-1], v}) : $signed({1'b0, v});
        mag  = (wide < 0) ? -wide : wide;
        return mag[DATA_WIDTH-1:0];
    endfunction

    // Per-digit +3 correction ahead of the shift; digits never carry into each other.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int d = 0; d < DIGITS; d++) begin
            if (s[4*d +: 4] >= 4'd5) r[4*d +: 4] = s[4*d +: 4] + 4'd3;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] operand_q;
    logic [BCD_W-1:0]      scratch_q;
    logic [BCD_W-1:0]      scratch_adj;
    logic [CNT_W-1:0]      cnt_q;
    logic                  sign_q;

    assign scratch_adj = add3(scratch_q);
    assign busy        = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            // Last shift happens on the edge that takes the counter to zero.
            SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand_q <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            bcd_out   <= '0;
            sign_out  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) operand_q <= data_in;
                end
                LOAD: begin
                    // The operand register doubles as the magnitude shift register.
                    operand_q <= magnitude(operand_q);
                    sign_q    <= (SIGNED_MODE != 0) && operand_q[DATA_WIDTH-1];
                    scratch_q <= '0;
                    cnt_q     <= CNT_W'(DATA_WIDTH);
                end
                SHIFT: begin
                    scratch_q <= {scratch_adj[BCD_W-2:0], operand_q[DATA_WIDTH-1]};
                    operand_q <= {operand_q[DATA_WIDTH-2:0], 1'b0};
                    cnt_q     <= cnt_q - CNT_W'(1);
                end
                DONE: begin
                    bcd_out  <= scratch_q;
                    sign_out <= sign_q;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_binary_to_bcd.sv
// tb_seq_binary_to_bcd: exercises signed 8-bit, unsigned 8-bit and unsigned
// 16-bit configurations against an arithmetic decimal-digit reference model.
module tb_seq_binary_to_bcd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        s_start = 1'b0, u_start = 1'b0, w_start = 1'b0;
    logic [7:0]  s_data = '0, u_data = '0;
    logic [15:0] w_data = '0;
    logic        s_busy, s_done, s_sign, u_busy, u_done, u_sign, w_busy, w_done, w_sign;
    logic [11:0] s_bcd, u_bcd;
    logic [19:0] w_bcd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_binary_to_bcd #(.DATA_WIDTH(8), .DIGITS(3), .SIGNED_MODE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .data_in(s_data),
        .busy(s_busy), .done(s_done), .bcd_out(s_bcd), .sign_out(s_sign));

    seq_binary_to_bcd #(.DATA_WIDTH(8), .DIGITS(3), .SIGNED_MODE(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .start(u_start), .data_in(u_data),
        .busy(u_busy), .done(u_done), .bcd_out(u_bcd), .sign_out(u_sign));

    seq_binary_to_bcd #(.DATA_WIDTH(16), .DIGITS(5), .SIGNED_MODE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(w_start), .data_in(w_data),
        .busy(w_busy), .done(w_done), .bcd_out(w_bcd), .sign_out(w_sign));

    // Decimal digits of |v|, ones digit in the low nibble.
    function automatic logic [19:0] ref_bcd(input longint v);
        longint     mag;
        logic [19:0] r;
        mag = (v < 0) ? -v : v;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        return r;
    endfunction

    function automatic longint as_signed8(input logic [7:0] d);
        return d[7] ? longint'(d) - 256 : longint'(d);
    endfunction

    function automatic bit digits_ok(input logic [19:0] b);
        bit ok = 1'b1;
        for (int i = 0; i < 5; i++) if (b[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    // Starts a conversion on one instance (0 signed8, 1 unsigned8, 2 unsigned16)
    // and waits for its done pulse. Called #1 after a rising edge with the DUT idle.
    // lat counts edges after the accepting edge; bcyc counts busy samples up to done.
    task automatic conv(input int which, input logic [15:0] d, output int lat,
                        output int bcyc, output logic [19:0] bcd, output logic sgn);
        logic dn, bz;
        lat = -1; bcyc = 0; bcd = '0; sgn = 1'b0;
        case (which)
            0: begin s_start = 1'b1; s_data = d[7:0]; end
            1: begin u_start = 1'b1; u_data = d[7:0]; end
            default: begin w_start = 1'b1; w_data = d; end
        endcase
        @(posedge clk); #1;
        s_start = 1'b0; u_start = 1'b0; w_start = 1'b0;
        for (int c = 0; c <= 40 && lat < 0; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            case (which)
                0: begin dn = s_done; bz = s_busy; end
                1: begin dn = u_done; bz = u_busy; end
                default: begin dn = w_done; bz = w_busy; end
            endcase
            if (bz) bcyc++;
            if (dn) begin
                lat = c;
                case (which)
                    0: begin bcd = {8'h0, s_bcd}; sgn = s_sign; end
                    1: begin bcd = {8'h0, u_bcd}; sgn = u_sign; end
                    default: begin bcd = w_bcd; sgn = w_sign; end
                endcase
            end
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({s_busy, s_done, s_sign, u_busy, u_done, u_sign, w_busy, w_done, w_sign} !== 9'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0",
                {s_busy, s_done, s_sign, u_busy, u_done, u_sign, w_busy, w_done, w_sign});
        end
        checks++;
        if ({s_bcd, u_bcd, w_bcd} !== 44'h0) begin
            errors++; $display("FAIL reset_bcd got %h exp 0", {s_bcd, u_bcd, w_bcd});
        end
        // start held during reset must not launch anything
        s_start = 1'b1; s_data = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored got %b exp 0", s_busy); end
        rst_n = 1'b1; s_start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (s_busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got %b exp 0", s_busy); end
    endtask

    task automatic test_directed;
        logic [15:0] sv_tab [4] = '{16'h85, 16'h80, 16'h7F, 16'h00};
        logic [15:0] uv_tab [3] = '{16'hFF, 16'h00, 16'h05};
        int lat, bcyc; logic [19:0] bcd; logic sgn; logic [19:0] exp_b; logic exp_s;
        for (int i = 0; i < 4; i++) begin
            conv(0, sv_tab[i], lat, bcyc, bcd, sgn);
            exp_b = ref_bcd(as_signed8(sv_tab[i][7:0]));
            exp_s = as_signed8(sv_tab[i][7:0]) < 0;
            checks++;
            if (lat !== 10) begin errors++; $display("FAIL s_latency d=%h got %0d exp 10", sv_tab[i], lat); end
            checks++;
            if (bcyc !== 10) begin errors++; $display("FAIL s_busy_cycles d=%h got %0d exp 10", sv_tab[i], bcyc); end
            checks++;
            if (bcd !== exp_b || sgn !== exp_s) begin
                errors++; $display("FAIL s_result d=%h got %b/%h exp %b/%h", sv_tab[i], sgn, bcd, exp_s, exp_b);
            end
        end
        for (int i = 0; i < 3; i++) begin
            conv(1, uv_tab[i], lat, bcyc, bcd, sgn);
            exp_b = ref_bcd(longint'(uv_tab[i][7:0]));
            checks++;
            if (lat !== 10 || bcd !== exp_b || sgn !== 1'b0) begin
                errors++; $display("FAIL u_result d=%h got lat %0d %b/%h exp lat 10 0/%h", uv_tab[i], lat, sgn, bcd, exp_b);
            end
        end
        conv(2, 16'hFFFF, lat, bcyc, bcd, sgn);
        checks++;
        if (lat !== 18 || bcyc !== 18) begin
            errors++; $display("FAIL w_latency got lat %0d busy %0d exp 18 18", lat, bcyc);
        end
        checks++;
        if (bcd !== 20'h65535 || sgn !== 1'b0) begin
            errors++; $display("FAIL w_result got %b/%h exp 0/65535", sgn, bcd);
        end
    endtask

    task automatic test_random;
        int lat, bcyc; logic [19:0] bcd; logic sgn; logic [19:0] exp_b; logic [15:0] d;
        for (int i = 0; i < 30; i++) begin
            d = 16'($urandom_range(0, 255));
            conv(0, d, lat, bcyc, bcd, sgn);
            exp_b = ref_bcd(as_signed8(d[7:0]));
            checks++;
            if (lat !== 10 || bcd !== exp_b || sgn !== (as_signed8(d[7:0]) < 0) || !digits_ok(bcd)) begin
                errors++; $display("FAIL rand_s d=%h got lat %0d %b/%h exp %h", d, lat, sgn, bcd, exp_b);
            end
            d = 16'($urandom_range(0, 255));
            conv(1, d, lat, bcyc, bcd, sgn);
            exp_b = ref_bcd(longint'(d[7:0]));
            checks++;
            if (lat !== 10 || bcd !== exp_b || sgn !== 1'b0 || !digits_ok(bcd)) begin
                errors++; $display("FAIL rand_u d=%h got lat %0d %b/%h exp %h", d, lat, sgn, bcd, exp_b);
            end
        end
        for (int i = 0; i < 8; i++) begin
            d = 16'($urandom);
            conv(2, d, lat, bcyc, bcd, sgn);
            exp_b = ref_bcd(longint'(d));
            checks++;
            if (lat !== 18 || bcd !== exp_b || !digits_ok(bcd)) begin
                errors++; $display("FAIL rand_w d=%h got lat %0d %h exp %h", d, lat, bcd, exp_b);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int ndone = 0; int first = -1; logic [11:0] got = '0;
        s_start = 1'b1; s_data = 8'd42;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            if (c == 3) begin s_start = 1'b1; s_data = 8'd99; end
            else s_start = 1'b0;
            @(posedge clk); #1;
            if (s_done) begin
                ndone++;
                if (first < 0) begin first = c; got = s_bcd; end
            end
        end
        s_start = 1'b0;
        checks++;
        if (ndone !== 1 || first !== 10) begin
            errors++; $display("FAIL busy_ignore_dones got %0d at %0d exp 1 at 10", ndone, first);
        end
        checks++;
        if (got !== 12'h042) begin errors++; $display("FAIL busy_ignore_value got %h exp 042", got); end
    endtask

    task automatic test_hold;
        int lat, bcyc; logic [19:0] bcd; logic sgn; logic [19:0] exp_b;
        bit held = 1'b1;
        conv(0, 16'h9C, lat, bcyc, bcd, sgn);
        exp_b = ref_bcd(as_signed8(8'h9C));
        for (int i = 0; i < 6; i++) begin
            s_data = 8'($urandom);
            @(posedge clk); #1;
            if (s_bcd !== exp_b[11:0] || s_sign !== 1'b1 || s_done !== 1'b0) held = 1'b0;
        end
        checks++;
        if (!held) begin errors++; $display("FAIL hold got %b/%h exp 1/%h", s_sign, s_bcd, exp_b[11:0]); end
    endtask

    task automatic test_back_to_back;
        int lat1, lat2, b1, b2; logic [19:0] bcd1, bcd2; logic sg1, sg2;
        logic [15:0] d1, d2;
        d1 = 16'($urandom_range(0, 255));
        d2 = 16'($urandom_range(0, 255));
        conv(0, d1, lat1, b1, bcd1, sg1);
        conv(0, d2, lat2, b2, bcd2, sg2);
        checks++;
        if (lat1 !== 10 || lat2 !== 10) begin
            errors++; $display("FAIL b2b_latency got %0d %0d exp 10 10", lat1, lat2);
        end
        checks++;
        if (bcd1 !== ref_bcd(as_signed8(d1[7:0])) || bcd2 !== ref_bcd(as_signed8(d2[7:0])) ||
            sg2 !== (as_signed8(d2[7:0]) < 0)) begin
            errors++; $display("FAIL b2b_value d=%h,%h got %h,%h exp %h,%h", d1, d2, bcd1, bcd2,
                ref_bcd(as_signed8(d1[7:0])), ref_bcd(as_signed8(d2[7:0])));
        end
    endtask

    task automatic test_reset_mid;
        int ndone = 0; int lat, bcyc; logic [19:0] bcd; logic sgn;
        s_start = 1'b1; s_data = 8'd200;
        @(posedge clk); #1;
        s_start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (s_busy !== 1'b0 || s_done !== 1'b0 || s_bcd !== 12'h0 || s_sign !== 1'b0) begin
            errors++; $display("FAIL mid_reset got busy %b done %b %b/%h exp all 0", s_busy, s_done, s_sign, s_bcd);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (s_done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL mid_reset_no_done got %0d exp 0", ndone); end
        conv(0, 16'd7, lat, bcyc, bcd, sgn);
        checks++;
        if (lat !== 10 || bcd !== 20'h007 || sgn !== 1'b0) begin
            errors++; $display("FAIL restart got lat %0d %b/%h exp 10 0/007", lat, sgn, bcd);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_busy_ignore;
        test_hold;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_binary_to_bcd.md
SEQ_BINARY_TO_BCD -- requirements
Module: seq_binary_to_bcd

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: binary operand width, legal range 4..32.
REQ-002 SHALL have parameter DIGITS, default 3: number of BCD output digits; 10**DIGITS SHALL exceed 2**DATA_WIDTH, otherwise elaboration fails.
REQ-003 SHALL have parameter SIGNED_MODE, default 1: 1 treats data_in as two's complement; 0 treats it as unsigned.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to convert data_in; sampled on the rising clk edge.
REQ-007 data_in  input  DATA_WIDTH  binary operand, captured on the accepted start.
REQ-008 busy  output  1  high while a conversion is in progress (states LOAD, SHIFT, DONE).
REQ-009 done  output  1  one-cycle pulse when bcd_out and sign_out are updated.
REQ-010 bcd_out  output  4*DIGITS  packed BCD; digit 0 (ones) at [3:0], hundreds at [11:8], and so on.
REQ-011 sign_out  output  1  1 when a SIGNED_MODE=1 operand was negative; always 0 when SIGNED_MODE=0.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, SHIFT and DONE.
REQ-013 IDLE: start=1 captures data_in into the operand register, goes to LOAD, busy=1; start=0 stays in IDLE.
REQ-014 LOAD (one cycle):
- magnitude = two's-complement absolute value if SIGNED_MODE=1 and MSB=1, else the raw operand.
- sign latched internally.
- BCD scratch register cleared.
- bit counter set to DATA_WIDTH.
- next state SHIFT.
REQ-015 Magnitude SHALL be computed at DATA_WIDTH+1 bits, so the most negative value (e.g. -128 at DATA_WIDTH=8) converts to +128 with no overflow.
REQ-016 SHIFT (exactly DATA_WIDTH cycles), each cycle:
- every scratch digit >= 5 gets +3 (4-bit, no carry between digits);
- then {scratch, magnitude} shifts left one bit;
- counter decrements.
REQ-017 SHIFT exits to DONE on the cycle the counter reaches 0.
REQ-018 DONE (one cycle): bcd_out <= scratch, sign_out <= latched sign, done=1, next state IDLE.
REQ-019 Latency: done SHALL assert exactly DATA_WIDTH+2 cycles after the edge that accepted start; busy is high for the same DATA_WIDTH+2 cycles.
REQ-020 start SHALL be ignored while busy=1; the in-flight operand is unaffected.
REQ-021 Accepted back-to-back: start high in the IDLE cycle after DONE; the minimum accepted-start period is DATA_WIDTH+3 cycles.
REQ-022 bcd_out and sign_out SHALL hold their last values between done pulses; they change only in DONE.
REQ-023 Every bcd_out digit SHALL always lie in 0..9.
REQ-024 Unused high digits SHALL read 0 (e.g. 5 yields 0x005).
REQ-025 Zero input, including SIGNED_MODE=1 zero, SHALL give bcd_out=0 and sign_out=0.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, bcd_out=0, sign_out=0, and clear the counter, scratch and operand, with no clk edge required.
REQ-027 A reset asserted mid-conversion SHALL abort it with no done pulse; the first accepted start after rst_n rises converts normally.
REQ-028 start SHALL be ignored while rst_n=0.

Verification
REQ-029 DATA_WIDTH=8, SIGNED_MODE=1, data_in=8'h85 (-123) -> done at cycle 10, sign_out=1, bcd_out=12'h123.
REQ-030 DATA_WIDTH=8, SIGNED_MODE=1, data_in=8'h80 -> sign_out=1, bcd_out=12'h128; data_in=8'h7F -> sign_out=0, bcd_out=12'h127.
REQ-031 DATA_WIDTH=8, SIGNED_MODE=0, data_in=8'hFF -> sign_out=0, bcd_out=12'h255; data_in=0 -> 12'h000.
REQ-032 start at cycle 0 (data 8'd42), then start at cycle 3 (data 8'd99) -> single done, bcd_out=12'h042; cycle-3 request dropped.
REQ-033 rst_n low at cycle 5 of a conversion of 8'd200 -> outputs zero at once, no done; restart with 8'd7 -> bcd_out=12'h007.
REQ-034 DATA_WIDTH=16, DIGITS=5, SIGNED_MODE=0, data_in=16'hFFFF -> done at cycle 18, bcd_out=20'h65535.
